// File: rtl/tea_decrypt.sv
`default_nettype none
// ============================================================================
//  Module   : tea_decrypt
//  Purpose  : Iterative TEA block decryptor. Recovers a 64-bit plaintext
//             (v1_dec, v2_dec) from a 64-bit ciphertext (v1_enc, v2_enc) under
//             a 128-bit key (key1..key4). One Feistel round per clock cycle,
//             with valid/ready handshakes on both the input and the output.
//  Ports    : clk                  - single rising-edge clock
//             reset                - asynchronous, active-high reset
//             in_valid / in_ready  - input handshake (in_ready high in IDLE)
//             v1_enc, v2_enc       - ciphertext words 0 and 1
//             key1..key4           - key words k0..k3, in encryptor order
//             out_valid / out_ready- output handshake (out_valid high in DONE)
//             v1_dec, v2_dec       - plaintext words 0 and 1 (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module tea_decrypt #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] v1_enc,
  input  logic [31:0] v2_enc,
  input  logic [31:0] key1,
  input  logic [31:0] key2,
  input  logic [31:0] key3,
  input  logic [31:0] key4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] v1_dec,
  output logic [31:0] v2_dec
);

  localparam int          CW       = $clog2(ROUNDS + 1);
  // Decryption walks the key schedule backwards, starting from the sum the
  // encryptor reaches after its last round (wraps mod 2^32).
  localparam logic [31:0] SUM_INIT = DELTA * 32'(ROUNDS);
  localparam logic [CW-1:0] LAST   = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     y;
  logic [31:0]     z;
  logic [31:0]     sum;
  logic [31:0]     k0;
  logic [31:0]     k1;
  logic [31:0]     k2;
  logic [31:0]     k3;
  logic [CW-1:0]   count;

  logic [31:0]     z_next;
  logic [31:0]     y_next;

  // Two round halves chained in one cycle: the y update uses the freshly
  // computed z, undoing the encryptor's halves in reverse order.
  assign z_next = z - ((((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3)));
  assign y_next = y - ((((z_next << 4) + k0) ^ (z_next + sum) ^ ((z_next >> 5) + k1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      z         <= '0;
      sum       <= '0;
      k0        <= '0;
      k1        <= '0;
      k2        <= '0;
      k3        <= '0;
      count     <= '0;
      v1_dec    <= '0;
      v2_dec    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y        <= v1_enc;
            z        <= v2_enc;
            k0       <= key1;
            k1       <= key2;
            k2       <= key3;
            k3       <= key4;
            sum      <= SUM_INIT;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          y     <= y_next;
          z     <= z_next;
          sum   <= sum - DELTA;
          count <= count + CW'(1);
          if (count == LAST) begin
            v1_dec    <= y_next;
            v2_dec    <= z_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Draining returns to IDLE; a new accept needs the following edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tea_decrypt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tea_decrypt
//  Purpose  : Self-checking bench for tea_decrypt. Three instances cover
//             ROUNDS = 32, 1 and 64. Plaintexts are encrypted by a reference
//             TEA encryptor, the ciphertext is decrypted by the design and a
//             scoreboard compares the result against the original plaintext.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tea_decrypt;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // index 0: ROUNDS=32, index 1: ROUNDS=1, index 2: ROUNDS=64
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] v1_enc    [3];
  logic [31:0] v2_enc    [3];
  logic [31:0] key1      [3];
  logic [31:0] key2      [3];
  logic [31:0] key3      [3];
  logic [31:0] key4      [3];
  logic [31:0] v1_dec    [3];
  logic [31:0] v2_dec    [3];
  logic [31:0] sum_int   [3];

  tea_decrypt #(.ROUNDS(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .v1_enc(v1_enc[0]), .v2_enc(v2_enc[0]),
    .key1(key1[0]), .key2(key2[0]), .key3(key3[0]), .key4(key4[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .v1_dec(v1_dec[0]), .v2_dec(v2_dec[0])
  );

  tea_decrypt #(.ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .v1_enc(v1_enc[1]), .v2_enc(v2_enc[1]),
    .key1(key1[1]), .key2(key2[1]), .key3(key3[1]), .key4(key4[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .v1_dec(v1_dec[1]), .v2_dec(v2_dec[1])
  );

  tea_decrypt #(.ROUNDS(64)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .v1_enc(v1_enc[2]), .v2_enc(v2_enc[2]),
    .key1(key1[2]), .key2(key2[2]), .key3(key3[2]), .key4(key4[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .v1_dec(v1_dec[2]), .v2_dec(v2_dec[2])
  );

  assign sum_int[0] = dut32.sum;
  assign sum_int[1] = dut1.sum;
  assign sum_int[2] = dut64.sum;

  typedef struct {
    int          idx;
    logic [31:0] p1;
    logic [31:0] p2;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   acc_cnt    = 0;
  logic prev_ov [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rounds_of(input int idx);
    case (idx)
      0:       return 32;
      1:       return 1;
      default: return 64;
    endcase
  endfunction

  // Reference TEA encryptor (straight from the algorithm definition).
  function automatic logic [63:0] tea_enc(input logic [31:0] p1, input logic [31:0] p2,
                                          input logic [31:0] k0, input logic [31:0] k1,
                                          input logic [31:0] k2, input logic [31:0] k3,
                                          input int n);
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] s;
    y = p1;
    z = p2;
    s = 32'd0;
    for (int r = 0; r < n; r++) begin
      s = s + DELTA;
      y = y + ((((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1)));
      z = z + ((((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3)));
    end
    return {y, z};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a handshake is about to complete.
  initial begin
    for (int i = 0; i < 3; i++) prev_ov[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          prev_ov[i] = 1'b0;
        end else begin
          if (in_valid[i] && in_ready[i]) acc_cnt++;
          if (out_valid[i] && !prev_ov[i])
            check("final_sum_zero", 64'(sum_int[i]), 64'd0);
          if (out_valid[i] && out_ready[i]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_output", {v1_dec[i], v2_dec[i]}, 64'hx);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("result_instance", 64'(i), 64'(e.idx));
              check("plaintext", {v1_dec[i], v2_dec[i]}, {e.p1, e.p2});
            end
          end
          prev_ov[i] = out_valid[i];
        end
      end
    end
  end

  // All driving happens 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cipher(input int idx, input logic [31:0] c1, input logic [31:0] c2,
                             input logic [31:0] k0, input logic [31:0] k1,
                             input logic [31:0] k2, input logic [31:0] k3,
                             input logic [31:0] p1, input logic [31:0] p2);
    int t;
    exp_t e;
    t = 0;
    while (!in_ready[idx] && t < 500) begin
      tick();
      t++;
    end
    if (!in_ready[idx]) begin
      check("accept_timeout", 64'(in_ready[idx]), 64'd1);
      return;
    end
    in_valid[idx] = 1'b1;
    v1_enc[idx]   = c1;
    v2_enc[idx]   = c2;
    key1[idx]     = k0;
    key2[idx]     = k1;
    key3[idx]     = k2;
    key4[idx]     = k3;
    e.idx = idx;
    e.p1  = p1;
    e.p2  = p2;
    exp_q.push_back(e);
    tick();
    in_valid[idx] = 1'b0;
  endtask

  task automatic send_random(input int idx);
    logic [31:0] p1, p2, k0, k1, k2, k3;
    logic [63:0] c;
    p1 = $urandom(); p2 = $urandom();
    k0 = $urandom(); k1 = $urandom(); k2 = $urandom(); k3 = $urandom();
    c  = tea_enc(p1, p2, k0, k1, k2, k3, rounds_of(idx));
    send_cipher(idx, c[63:32], c[31:0], k0, k1, k2, k3, p1, p2);
  endtask

  task automatic wait_out(input int idx, output int lat);
    lat = 0;
    while (!out_valid[idx] && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic churn_inputs(input int idx);
    v1_enc[idx] = $urandom(); v2_enc[idx] = $urandom();
    key1[idx] = $urandom(); key2[idx] = $urandom();
    key3[idx] = $urandom(); key4[idx] = $urandom();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int a0;
    logic [63:0] held;
    logic stable;
    int t_acc [6];

    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1;
      v1_enc[i] = '0; v2_enc[i] = '0;
      key1[i] = '0; key2[i] = '0; key3[i] = '0; key4[i] = '0;
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_handshake", 64'({in_ready[i], out_valid[i]}), 64'b10);
      check("reset_outputs", {v1_dec[i], v2_dec[i]}, 64'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Known vector: zero key, zero plaintext.
    send_cipher(0, 32'h41EA3A0A, 32'h94BAA940, '0, '0, '0, '0, '0, '0);
    wait_out(0, lat);
    check("known_latency", 64'(lat), 64'd32);
    drain();

    // Backpressure: hold out_ready low for 10 cycles after out_valid.
    out_ready[0] = 1'b0;
    send_random(0);
    wait_out(0, lat);
    held   = {v1_dec[0], v2_dec[0]};
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({v1_dec[0], v2_dec[0]} !== held || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1)
        stable = 1'b0;
    end
    check("backpressure_stable", 64'(stable), 64'd1);
    out_ready[0] = 1'b1;
    tick();
    check("backpressure_release", 64'({out_valid[0], in_ready[0]}), 64'b01);
    drain();

    // Input churn with in_valid held high while the job runs and stalls.
    out_ready[0] = 1'b0;
    a0 = acc_cnt;
    send_random(0);
    in_valid[0] = 1'b1;
    for (int i = 0; i < 45; i++) begin
      churn_inputs(0);
      tick();
    end
    check("churn_single_accept", 64'(acc_cnt - a0), 64'd1);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    drain();

    // Asynchronous reset at round 17, then a fresh job.
    send_random(0);
    repeat (17) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrun_reset_handshake", 64'({in_ready[0], out_valid[0]}), 64'b10);
    check("midrun_reset_outputs", {v1_dec[0], v2_dec[0]}, 64'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    send_random(0);
    wait_out(0, lat);
    check("post_reset_latency", 64'(lat), 64'd32);
    drain();

    // Back-to-back with out_ready tied high.
    for (int j = 0; j < 6; j++) begin
      send_random(0);
      t_acc[j] = cyc;
      if (j > 0) check("b2b_period", 64'(t_acc[j] - t_acc[j-1]), 64'd34);
    end
    drain();

    // Random round trips, ROUNDS=32, with random output stalls.
    for (int j = 0; j < 200; j++) begin
      out_ready[0] = 1'b0;
      send_random(0);
      repeat ($urandom_range(0, 40)) tick();
      out_ready[0] = 1'b1;
      drain();
    end

    // Random round trips, ROUNDS=1 and ROUNDS=64, back-to-back.
    for (int j = 0; j < 200; j++) send_random(1);
    drain();
    for (int j = 0; j < 200; j++) send_random(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tea_decrypt.md
# tea_decrypt

Iterative TEA (Tiny Encryption Algorithm) decryptor: it recovers a 64-bit plaintext block (v1, v2) from a 64-bit ciphertext block under a 128-bit key (key1..key4). It is the receive-side counterpart of the team's TEA encryptor, which uses the same word ordering, key ordering and delta. The datapath performs one Feistel round per clock and uses a valid/ready handshake on both input and output, so it can sit directly behind a link receiver or a FIFO.

## Interface
- ROUNDS, 32: number of TEA cycles, legal range 1..64. It must match the encryptor.
- DELTA, 32'h9E3779B9: key-schedule constant.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  ciphertext block and key are presented.
- in_ready  output  1  block can accept a new job; equals (state == IDLE).
- v1_enc  input  32  ciphertext word 0 (the encryptor's v1_enc).
- v2_enc  input  32  ciphertext word 1 (the encryptor's v2_enc).
- key1..key4  input  32 each  key words k0..k3, in encryptor order.
- out_valid  output  1  v1_dec/v2_dec hold a finished plaintext.
- out_ready  input  1  downstream accepts the plaintext.
- v1_dec  output  32  plaintext word 0.
- v2_dec  output  32  plaintext word 1.

## Operation
- State machine:
  - IDLE: in_ready=1. Goes to RUN on the edge where in_valid && in_ready.
  - RUN: runs the rounds. Goes to DONE on the edge that completes round ROUNDS.
  - DONE: out_valid=1. Goes to IDLE on the edge where out_valid && out_ready.
- Accept edge actions:
  - Register v1_enc→y, v2_enc→z, and key1..key4→k0..k3. Inputs may change freely after this edge.
  - Load sum ← (DELTA*ROUNDS) mod 2^32. For ROUNDS=32 this is 32'hC6EF3720.
  - Load round counter ← 0. The counter is $clog2(ROUNDS+1) bits wide.
- Each RUN edge performs one round, all arithmetic mod 2^32, shifts logical:
  - z ← z − (((y<<4)+k2) ^ (y+sum) ^ ((y>>5)+k3))
  - y ← y − (((z'<<4)+k0) ^ (z'+sum) ^ ((z'>>5)+k1)), where z' is the new z computed in the same cycle (combinational chain).
  - sum ← sum − DELTA; counter ← counter+1.
- After the final round, sum must equal 0. The bench checks this as an internal assertion.
- Outputs: v1_dec=y and v2_dec=z are registered on the final-round edge. They stay stable for as long as out_valid=1 && out_ready=0.
- in_valid is ignored in RUN and DONE; no job is queued.
- A new job cannot be accepted on the same edge that DONE is drained. The minimum job period is ROUNDS+2 cycles.
- out_ready outside DONE has no effect.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, v1_dec=0, v2_dec=0; internal y, z, sum, counter and keys are 0.
- Accept at edge E0. Rounds execute at edges E1..E_ROUNDS. out_valid rises after E_ROUNDS.
- Latency from accept to out_valid: ROUNDS cycles (32 by default).
- out_valid falls on the edge after the handshake. in_ready rises on that same edge.
- Reset mid-RUN or mid-DONE: the job is aborted and every output returns to its reset value asynchronously. The first accept is possible on the first edge after reset deasserts.
- Changing in_valid, v*_enc or key* during RUN or DONE has no effect on the job in flight.
- Critical path: two chained 32-bit round halves, i.e. four adders plus XORs. No pipelining is required at the target clock.

## Test plan
- Known vector: key=0, v1_enc=32'h41EA3A0A, v2_enc=32'h94BAA940 → after 32 cycles out_valid=1, v1_dec=0, v2_dec=0.
- Round trip: 200 random blocks and keys are encrypted by the reference C model, then decrypted by the DUT → DUT output equals the original plaintext every time. This runs with ROUNDS=32 and again with ROUNDS=1 and ROUNDS=64.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stay stable and in_ready stays 0. Raise out_ready → out_valid drops and in_ready rises on the next edge.
- Input churn: after accept, randomize v*_enc and key* every cycle while keeping in_valid=1 → the result matches the accepted block, and no second job starts until DONE is drained.
- Reset at round 17 → out_valid=0, v1_dec=v2_dec=0 and in_ready=1 immediately. A fresh job after reset returns the correct plaintext with the full 32-cycle latency.
- Back-to-back with out_ready tied to 1 → accepts occur exactly every ROUNDS+2 cycles (34 for the default) and no out_valid pulse is lost.
